// File: rtl/csr_reg_pkg.sv
// Shared CSR address map, mstatus field positions, write masks and helpers
// for the machine-mode CSR file (csr_reg) and its counter sub-module.
package csr_reg_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_WMASK = (32'h1 << MSTATUS_MIE) | (32'h1 << MSTATUS_MPIE);
  localparam logic [31:0] MSTATUS_FIXED = 32'h3 << MSTATUS_MPP_LO;
  localparam logic [31:0] MSTATUS_RST   = MSTATUS_FIXED;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MISA_DEFAULT  = 32'h4000_0100;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  // Value a register actually takes when written; MPP is pinned to M-mode.
  function automatic logic [31:0] csr_wmask(input logic [11:0] a, input logic [31:0] d);
    case (a)
      CSR_MSTATUS: csr_wmask = (d & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MTVEC:   csr_wmask = d & MTVEC_WMASK;
      CSR_MEPC:    csr_wmask = d & MEPC_WMASK;
      default:     csr_wmask = d;
    endcase
  endfunction

  function automatic logic csr_writable(input logic [11:0] a, input logic cnt_en);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL:           csr_writable = 1'b1;
      CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MINSTRET, CSR_MINSTRETH:               csr_writable = cnt_en;
      default:                                   csr_writable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_reg_counter64.sv
// 64-bit free-running/event counter with independent half-word writes;
// any write cycle suppresses the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) value[31:0]  <= wdata[31:0];
      if (we_hi) value[63:32] <= wdata[63:32];
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file: decode read port, execute write port, clint r/w port.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter logic [31:0] MISA_VAL  = MISA_DEFAULT,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        retire_i,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic [31:0] clint_raddr_i,
  output logic [31:0] clint_rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

`ifdef CSR_COUNTERS_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  localparam int NUM_RPORTS = 2;

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;
  csr_wr_t     cw, ew;

  logic unused_upper_addr;
  assign unused_upper_addr = ^{raddr_i[31:12], waddr_i[31:12],
                               clint_waddr_i[31:12], clint_raddr_i[31:12]};

  // clint wins a same-address collision; the execute write is then dropped.
  always_comb begin
    cw      = '0;
    ew      = '0;
    cw.addr = clint_waddr_i[11:0];
    cw.data = csr_wmask(clint_waddr_i[11:0], clint_wdata_i);
    cw.en   = clint_we_i && csr_writable(clint_waddr_i[11:0], CNT_EN);
    ew.addr = waddr_i[11:0];
    ew.data = csr_wmask(waddr_i[11:0], wdata_i);
    ew.en   = we_i && csr_writable(waddr_i[11:0], CNT_EN)
              && !(cw.en && (cw.addr == ew.addr));
  end

  // {hit, data} of the write landing on address a this cycle, if any.
  function automatic logic [32:0] wr_for(input logic [11:0] a, input csr_wr_t c,
                                         input csr_wr_t e);
    if (c.en && c.addr == a)      wr_for = {1'b1, c.data};
    else if (e.en && e.addr == a) wr_for = {1'b1, e.data};
    else                          wr_for = '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (ew.en) begin
        case (ew.addr)
          CSR_MSTATUS:  mstatus_q  <= ew.data;
          CSR_MIE:      mie_q      <= ew.data;
          CSR_MTVEC:    mtvec_q    <= ew.data;
          CSR_MSCRATCH: mscratch_q <= ew.data;
          CSR_MEPC:     mepc_q     <= ew.data;
          CSR_MCAUSE:   mcause_q   <= ew.data;
          CSR_MTVAL:    mtval_q    <= ew.data;
          default: ;
        endcase
      end
      if (cw.en) begin
        case (cw.addr)
          CSR_MSTATUS:  mstatus_q  <= cw.data;
          CSR_MIE:      mie_q      <= cw.data;
          CSR_MTVEC:    mtvec_q    <= cw.data;
          CSR_MSCRATCH: mscratch_q <= cw.data;
          CSR_MEPC:     mepc_q     <= cw.data;
          CSR_MCAUSE:   mcause_q   <= cw.data;
          CSR_MTVAL:    mtval_q    <= cw.data;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [32:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
  assign cyc_lo = wr_for(CSR_MCYCLE,    cw, ew);
  assign cyc_hi = wr_for(CSR_MCYCLEH,   cw, ew);
  assign ins_lo = wr_for(CSR_MINSTRET,  cw, ew);
  assign ins_hi = wr_for(CSR_MINSTRETH, cw, ew);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (cyc_lo[32]),
    .we_hi (cyc_hi[32]),
    .wdata ({cyc_hi[31:0], cyc_lo[31:0]}),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_i),
    .we_lo (ins_lo[32]),
    .we_hi (ins_hi[32]),
    .wdata ({ins_hi[31:0], ins_lo[31:0]}),
    .value (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire_i;
  assign mcycle   = '0;
  assign minstret = '0;
`endif

  // Port 0 is decode, port 1 is clint; both see the same map and bypass.
  logic [NUM_RPORTS-1:0][11:0] rd_addr;
  logic [NUM_RPORTS-1:0][31:0] rd_data;
  logic [NUM_RPORTS-1:0][32:0] rd_byp;

  assign rd_addr[0] = raddr_i[11:0];
  assign rd_addr[1] = clint_raddr_i[11:0];

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    assign rd_byp[p] = wr_for(rd_addr[p], cw, ew);

    always_comb begin
      rd_data[p] = '0;
      case (rd_addr[p])
        CSR_MSTATUS:                  rd_data[p] = mstatus_q;
        CSR_MISA:                     rd_data[p] = MISA_VAL;
        CSR_MIE:                      rd_data[p] = mie_q;
        CSR_MTVEC:                    rd_data[p] = mtvec_q;
        CSR_MSCRATCH:                 rd_data[p] = mscratch_q;
        CSR_MEPC:                     rd_data[p] = mepc_q;
        CSR_MCAUSE:                   rd_data[p] = mcause_q;
        CSR_MTVAL:                    rd_data[p] = mtval_q;
        CSR_MCYCLE,    CSR_CYCLE:     rd_data[p] = mcycle[31:0];
        CSR_MCYCLEH,   CSR_CYCLEH:    rd_data[p] = mcycle[63:32];
        CSR_MINSTRET,  CSR_INSTRET:   rd_data[p] = minstret[31:0];
        CSR_MINSTRETH, CSR_INSTRETH:  rd_data[p] = minstret[63:32];
        default: ;
      endcase
      if (rd_byp[p][32]) rd_data[p] = rd_byp[p][31:0];
    end
  end

  assign rdata_o         = rd_data[0];
  assign clint_rdata_o   = rd_data[1];
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_q;
  assign global_int_en_o = mstatus_q[MSTATUS_MIE];

endmodule
